// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner that latches the input frame into a shadow at frame boundaries and drives registered digit/anode outputs.
// Optional ghost blanking is enabled by defining DISP_GHOST_BLANK_EN.
module display_scan_mux #(
  parameter int unsigned NUM_DIGITS       = 8,
  parameter int unsigned DIGIT_W          = 4,
  parameter int unsigned TICK_DIV         = 100000,
  parameter int unsigned ANODE_ACTIVE_LOW = 1,
  parameter int unsigned BLANK_CYCLES     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_in,
  input  logic                            load,
  input  logic [NUM_DIGITS-1:0]           digit_en,
  output logic [DIGIT_W-1:0]              digit_out,
  output logic [NUM_DIGITS-1:0]           anode,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_done
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] frame_t;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  frame_t                shadow_q, shadow_d;
  frame_t                capture_q, capture_d;
  logic                  pending_q, pending_d;
  logic [DIGIT_W-1:0]    digit_out_q, digit_out_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [IW-1:0]         digit_idx_q;
  logic                  frame_done_q, frame_done_d;
  logic                  tick, wrap;
  logic [NUM_DIGITS-1:0] act;

`ifdef DISP_GHOST_BLANK_EN
  localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
`endif

  always_comb begin
    tick      = (presc_q == PRE_LAST);
    wrap      = tick && (idx_q == IDX_LAST);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    // Capture keeps only the latest load; shadow moves only on the wrap tick.
    capture_d = load ? frame_t'(digits_in) : capture_q;
    pending_d = pending_q | load;
    shadow_d  = shadow_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (load)           shadow_d = frame_t'(digits_in);
      else if (pending_q) shadow_d = capture_q;
    end

    act        = '0;
    act[idx_q] = digit_en[idx_q];
`ifdef DISP_GHOST_BLANK_EN
    if (presc_q < BLANK_LIM) act = '0;
`endif
    anode_d      = (ANODE_ACTIVE_LOW != 0) ? ~act : act;
    digit_out_d  = shadow_q[idx_q];
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      capture_q    <= '0;
      pending_q    <= 1'b0;
      digit_out_q  <= '0;
      anode_q      <= ANODE_OFF;
      digit_idx_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      capture_q    <= capture_d;
      pending_q    <= pending_d;
      digit_out_q  <= digit_out_d;
      anode_q      <= anode_d;
      digit_idx_q  <= idx_q;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_out  = digit_out_q;
  assign anode      = anode_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: a cycle/frame arithmetic model predicts every registered output.
`timescale 1ns/1ps
module tb_display_scan_mux;

  localparam int N     = 4;
  localparam int W     = 4;
  localparam int T     = 4;
  localparam int B     = 2;
  localparam int FRAME = N * T;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [N*W-1:0] digits_in = '0;
  logic [N-1:0]   digit_en = '1;
  logic [W-1:0]   digit_out;
  logic [N-1:0]   anode;
  logic [1:0]     digit_idx;
  logic           frame_done;

  display_scan_mux #(
    .NUM_DIGITS(N), .DIGIT_W(W), .TICK_DIV(T), .ANODE_ACTIVE_LOW(1), .BLANK_CYCLES(B)
  ) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .digit_en(digit_en),
    .digit_out(digit_out), .anode(anode), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] an;
    logic [1:0]   idx;
    logic         fd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Model: cycle count since reset, frame currently shown, latest load seen this frame.
  int             c = 0;
  logic [N*W-1:0] cur = '0;
  logic [N*W-1:0] nxt = '0;
  bit             has = 0;

  function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endfunction

  task automatic step(input logic r, input logic l, input logic [N*W-1:0] d, input logic [N-1:0] e);
    exp_t x;
    int   slot;
    @(negedge clk);
    rst = r; load = l; digits_in = d; digit_en = e;
    if (r) begin
      x.d = '0; x.an = '1; x.idx = '0; x.fd = 1'b0;
      c = 0; cur = '0; has = 0;
    end else begin
      slot  = (c / T) % N;
      x.d   = cur[slot*W +: W];
      x.an  = '1;
      if (e[slot]) x.an[slot] = 1'b0;
`ifdef DISP_GHOST_BLANK_EN
      if ((c % T) < B) x.an = '1;
`endif
      x.idx = 2'(slot);
      x.fd  = ((c % FRAME) == FRAME - 1);
      if (l) begin nxt = d; has = 1; end
      if ((c % FRAME) == FRAME - 1) begin
        if (has) cur = nxt;
        has = 0;
      end
      c++;
    end
    q.push_back(x);
  endtask

  task automatic idle(input logic [N-1:0] e);
    step(1'b0, 1'b0, 16'($urandom), e);
  endtask

  task automatic run_to(input int pos);
    while ((c % FRAME) != pos) idle(4'hF);
  endtask

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("digit_out",  32'(digit_out),  32'(x.d));
      chk("anode",      32'(anode),      32'(x.an));
      chk("digit_idx",  32'(digit_idx),  32'(x.idx));
      chk("frame_done", 32'(frame_done), 32'(x.fd));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic r, l;
    logic [N-1:0] e;
    step(1'b1, 1'b0, '0, 4'hF);
    step(1'b1, 1'b1, 16'h9999, 4'hF);
    // Basic scan with 4321 loaded in the first frame
    step(1'b0, 1'b1, 16'h4321, 4'hF);
    repeat (2*FRAME - 1) idle(4'hF);
    // Tear-free mid-frame load at slot 2
    run_to(2*T);
    step(1'b0, 1'b1, 16'hABCD, 4'hF);
    run_to(0);
    repeat (FRAME) idle(4'hF);
    // Early load superseded by a load on the wrap tick
    step(1'b0, 1'b1, 16'h1111, 4'hF);
    run_to(FRAME - 1);
    step(1'b0, 1'b1, 16'h5678, 4'hF);
    repeat (FRAME) idle(4'hF);
    // Enable mask
    repeat (FRAME) idle(4'b0101);
    // Reset in slot 3 with a load pending
    run_to(T);
    step(1'b0, 1'b1, 16'hFEDC, 4'hF);
    run_to(3*T + 1);
    step(1'b1, 1'b0, '0, 4'hF);
    repeat (2*FRAME) idle(4'hF);
    // Randomized traffic
    repeat (3000) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step(r, l, 16'($urandom), e);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Parametrised time-multiplexed digit scanner for the multi-digit 7-segment display path.
- Steps through NUM_DIGITS values of DIGIT_W bits and drives one digit code plus a one-hot anode per scan slot.
- Holds a tear-free shadow copy of the inputs.
- Sits between the display data sources and the segment decoder; replaces the fixed 8-input select mux plus its external select counter.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16).
- DIGIT_W, 4, bits per digit code.
- TICK_DIV, 100000, clk cycles per digit slot (>=2).
- ANODE_ACTIVE_LOW, 1, 1: active anode driven 0; 0: active anode driven 1.
- BLANK_CYCLES, 16, ghost-blank length in clk cycles; used only with the optional feature; must be < TICK_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- digits_in  in  NUM_DIGITS*DIGIT_W  packed digit codes; digit k is at bits [k*DIGIT_W +: DIGIT_W].
- load  in  1  request to capture digits_in into the shadow register.
- digit_en  in  NUM_DIGITS  per-digit enable mask; a digit whose bit is 0 keeps its anode inactive.
- digit_out  out  DIGIT_W  code of the currently scanned digit, to the segment decoder.
- anode  out  NUM_DIGITS  one-hot anode drive, polarity set by ANODE_ACTIVE_LOW.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the current slot.
- frame_done  out  1  one-cycle pulse when the index wraps to 0.

Behaviour:
- Reset (rst=1 at a clk edge), values registered on that edge:
  - prescaler=0, idx=0, shadow=0, pending=0.
  - digit_out=0, digit_idx=0, frame_done=0, anode = all inactive.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - The "tick" is the cycle in which prescaler==TICK_DIV-1.
- Index:
  - On a tick, idx increments.
  - If idx==NUM_DIGITS-1 on a tick, idx goes to 0 and frame_done=1 for the next cycle only.
  - Non-power-of-2 NUM_DIGITS never reaches idx >= NUM_DIGITS.
- Load handshake:
  - load=1 sets pending.
  - On the wrap tick, shadow is updated:
    - if load=1 in that same cycle, shadow <= digits_in of that cycle;
    - else if pending=1, shadow <= digits_in latched at the most recent load.
  - pending clears on the wrap tick.
  - A 1-entry capture register holds the latest load data, so multiple loads within one frame keep only the last.
  - The shadow therefore changes only at frame boundaries; no mixed-frame display.
- Outputs, registered, 1-cycle latency from idx:
  - digit_out <= shadow[idx].
  - digit_idx <= idx.
  - anode bit idx active iff digit_en[idx]=1; all other bits inactive.
  - digit_en is sampled every cycle, so a mask change takes effect on the next cycle mid-slot.
- First cycle after reset release: digit_idx=0, anode shows digit 0 per digit_en[0], digit_out=0.
- Reset asserted mid-frame overrides everything in the same edge: any pending load is discarded and the shadow returns to 0.
- All counters are unsigned and width-sized via $clog2; no overflow beyond terminal values.

Optional Feature:
- Macro: DISP_GHOST_BLANK_EN.
- Defined:
  - All anodes are held inactive for the first BLANK_CYCLES cycles of every slot (prescaler < BLANK_CYCLES), then behave normally.
  - digit_out and digit_idx still update at slot start.
  - Suppresses ghosting during segment transitions.
- Undefined:
  - No blanking; anode is active for the whole slot.
  - BLANK_CYCLES is ignored and no blank logic is synthesised.

Test Plan:
1. Reset and scan, NUM_DIGITS=4, TICK_DIV=4, digit_en=4'hF, ANODE_ACTIVE_LOW=1, load digits_in=16'h4321 then release.
   - After the first wrap, anode cycles 1110,1101,1011,0111, each held 4 cycles.
   - digit_out is 1,2,3,4 in step.
   - frame_done pulses once every 16 cycles.
2. Tear-free load: mid-frame at idx=2, pulse load with 16'hABCD.
   - digit_out remains 3,4 for the rest of the frame.
   - Next frame shows D,C,B,A; pending clears at the wrap.
3. Load coincident with wrap tick plus an earlier load in the same frame: earlier 16'h1111, wrap-cycle 16'h5678.
   - Next frame shows 8,7,6,5; 1111 is never displayed.
4. Mask: digit_en=4'b0101.
   - Anode bits 1 and 3 are never active (stay 1).
   - Slot timing unchanged; digit_idx still visits 0..3.
5. Reset mid-frame at idx=3 with pending=1.
   - Next cycle: anode=1111, digit_out=0, digit_idx=0, frame_done=0.
   - The pending data never appears.
6. With DISP_GHOST_BLANK_EN, TICK_DIV=8, BLANK_CYCLES=2.
   - Each slot shows anode=all-1s for 2 cycles, then the active digit for 6 cycles.
   - Without the macro, active for all 8 cycles.
